// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer for the Viterbi datapath: clears ACS metrics, paces symbol
// intake, writes the survivor window and launches normal/flush tracebacks.
module viterbi_acs_ctrl #(
    parameter int TB_DEPTH = 64,
    parameter int FRAME_W  = 16,
    parameter int ADDR_W   = $clog2(TB_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_constr_len,
    input  logic [FRAME_W-1:0] i_frame_len,
    input  logic               i_sym_valid,
    output logic               o_sym_ready,
    output logic               o_en_acs,
    output logic               o_acs_rst_n,
    output logic               o_constr_len,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic               o_tb_start,
    output logic [ADDR_W-1:0]  o_tb_addr,
    output logic               o_tb_flush,
    input  logic               i_tb_done,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0]  WPTR_MAX = ADDR_W'(TB_DEPTH - 1);
    localparam logic [FRAME_W-1:0] FILL_MAX = FRAME_W'(TB_DEPTH - 1);

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] frame_len, sym_cnt;
    logic [ADDR_W-1:0]  wptr, last_addr;
    logic               tb_busy, flush_sent;
    logic               ready, accept, frame_end, fill_end, run_tb, flush_issue;

    assign ready       = ((state == FILL) || (state == RUN)) && !tb_busy;
    assign accept      = i_sym_valid && ready;
    assign frame_end   = accept && ((sym_cnt + FRAME_W'(1)) == frame_len);
    assign fill_end    = accept && (sym_cnt == FILL_MAX);
    assign run_tb      = accept && (state == RUN);
    assign flush_issue = (state == FLUSH) && !tb_busy && !flush_sent;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (i_frame_len == '0) ? DONE : CLEAR;
            CLEAR:   state_nxt = FILL;
            FILL:    if (frame_end) state_nxt = FLUSH;
                     else if (fill_end) state_nxt = RUN;
            RUN:     if (frame_end) state_nxt = FLUSH;
            FLUSH:   if (flush_sent && tb_busy && i_tb_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_sym_ready = ready;
        o_en_acs    = accept;
        o_wr_en     = accept;
        o_wr_addr   = wptr;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_len    <= '0;
            sym_cnt      <= '0;
            wptr         <= '0;
            last_addr    <= '0;
            tb_busy      <= 1'b0;
            flush_sent   <= 1'b0;
            o_acs_rst_n  <= 1'b0;
            o_constr_len <= 1'b0;
            o_tb_start   <= 1'b0;
            o_tb_addr    <= '0;
            o_tb_flush   <= 1'b0;
        end else begin
            o_acs_rst_n <= (state_nxt != CLEAR);
            o_tb_start  <= 1'b0;
            o_tb_flush  <= 1'b0;

            if ((state == IDLE) && i_start) begin
                frame_len    <= i_frame_len;
                o_constr_len <= i_constr_len;
                sym_cnt      <= '0;
                wptr         <= '0;
                flush_sent   <= 1'b0;
            end

            if (accept) begin
                sym_cnt   <= sym_cnt + FRAME_W'(1);
                wptr      <= (wptr == WPTR_MAX) ? '0 : wptr + ADDR_W'(1);
                last_addr <= wptr;
            end

            if (run_tb) begin
                o_tb_start <= 1'b1;
                o_tb_addr  <= wptr;
            end else if (flush_issue) begin
                o_tb_start <= 1'b1;
                o_tb_addr  <= last_addr;
                o_tb_flush <= 1'b1;
                flush_sent <= 1'b1;
            end

            // A launch can only happen while idle, so set never meets a real done.
            if (run_tb || flush_issue) tb_busy <= 1'b1;
            else if (i_tb_done)        tb_busy <= 1'b0;
        end
    end

endmodule
